// File: rtl/dma_desc_split.sv
// Splits one DMA descriptor into boundary-aligned sub-descriptors,
// tracks their completions and returns a single parent status.
module dma_desc_split #(
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int RAM_SEL_WIDTH   = 2,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_SEG_LEN     = 4096,
    parameter int OUTSTANDING     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PCIE_ADDR_WIDTH-1:0] s_axis_desc_pcie_addr,
    input  logic [RAM_SEL_WIDTH-1:0]   s_axis_desc_ram_sel,
    input  logic [RAM_ADDR_WIDTH-1:0]  s_axis_desc_ram_addr,
    input  logic [LEN_WIDTH-1:0]       s_axis_desc_len,
    input  logic [TAG_WIDTH-1:0]       s_axis_desc_tag,
    input  logic                       s_axis_desc_valid,
    output logic                       s_axis_desc_ready,
    output logic [PCIE_ADDR_WIDTH-1:0] m_axis_desc_pcie_addr,
    output logic [RAM_SEL_WIDTH-1:0]   m_axis_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]  m_axis_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]       m_axis_desc_len,
    output logic [TAG_WIDTH-1:0]       m_axis_desc_tag,
    output logic                       m_axis_desc_valid,
    input  logic                       m_axis_desc_ready,
    input  logic [TAG_WIDTH-1:0]       s_axis_desc_status_tag,
    input  logic                       s_axis_desc_status_valid,
    output logic [TAG_WIDTH-1:0]       m_axis_desc_status_tag,
    output logic                       m_axis_desc_status_valid,
    input  logic                       enable,
    output logic                       busy,
    output logic                       status_error
);

    localparam int SEG_BITS = $clog2(MAX_SEG_LEN);
    localparam int OUT_W    = $clog2(OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX =
        OUT_W'(OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0] SEG_LEN =
        LEN_WIDTH'(MAX_SEG_LEN);
    localparam logic [LEN_WIDTH-1:0] TAG_MASK =
        LEN_WIDTH'(OUTSTANDING - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [PCIE_ADDR_WIDTH-1:0] addr_q;
    logic [RAM_SEL_WIDTH-1:0]   sel_q;
    logic [RAM_ADDR_WIDTH-1:0]  ram_q;
    logic [LEN_WIDTH-1:0]       rem_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [LEN_WIDTH-1:0]       cnt_q;
    logic [OUT_W-1:0]           out_q, out_d;
    logic                       init_q;
    logic                       busy_q;
    logic                       err_q;

    logic [LEN_WIDTH-1:0]       seg_off;
    logic [LEN_WIDTH-1:0]       room;
    logic [LEN_WIDTH-1:0]       chunk;
    logic                       s_hs;
    logic                       m_hs;
    logic                       st_ok;

    // Bytes left before the next MAX_SEG_LEN boundary
    assign seg_off = LEN_WIDTH'(addr_q[SEG_BITS-1:0]);
    assign room    = SEG_LEN - seg_off;
    assign chunk   = (rem_q < room) ? rem_q : room;

    assign s_axis_desc_ready = (state_q == IDLE) && enable && init_q;
    assign m_axis_desc_valid = (state_q == ISSUE) && (out_q < OUT_MAX);

    assign s_hs  = s_axis_desc_ready && s_axis_desc_valid;
    assign m_hs  = m_axis_desc_valid && m_axis_desc_ready;
    assign st_ok = s_axis_desc_status_valid && (out_q != '0);

    assign m_axis_desc_pcie_addr    = addr_q;
    assign m_axis_desc_ram_sel      = sel_q;
    assign m_axis_desc_ram_addr     = ram_q;
    assign m_axis_desc_len          = chunk;
    assign m_axis_desc_tag          = TAG_WIDTH'(cnt_q & TAG_MASK);
    assign m_axis_desc_status_valid = (state_q == DONE);
    assign m_axis_desc_status_tag   = tag_q;
    assign busy                     = busy_q;
    assign status_error             = err_q;

    always_comb begin
        out_d = out_q;
        case ({m_hs, st_ok})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    state_d = (s_axis_desc_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (m_hs && (chunk == rem_q)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (out_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            ram_q   <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            out_q   <= out_d;
            err_q   <= s_axis_desc_status_valid && (out_q == '0);
            if (s_hs) begin
                addr_q <= s_axis_desc_pcie_addr;
                sel_q  <= s_axis_desc_ram_sel;
                ram_q  <= s_axis_desc_ram_addr;
                rem_q  <= s_axis_desc_len;
                tag_q  <= s_axis_desc_tag;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end
            if (m_hs) begin
                addr_q <= addr_q + PCIE_ADDR_WIDTH'(chunk);
                ram_q  <= ram_q + RAM_ADDR_WIDTH'(chunk);
                rem_q  <= rem_q - chunk;
                cnt_q  <= cnt_q + 1'b1;
            end
            // Busy drops with the status pulse, or after it for len=0
            if ((state_q == WAIT && state_d == DONE) ||
                state_q == DONE) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
